ahb_lite_master: RTL

//  AHB-Lite bus initiator for the testbench/SoC fabric: it is the master end that drives the slave-side bus.

---
 rtl/ahb_pkg.sv | 7 +
 rtl/ahb_lite_master.sv | 101 ++++++++++
 2 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite transfer encodings
package ahb_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11} htrans_e;
  typedef enum logic [2:0] {SINGLE = 3'b000} hburst_e;
  typedef enum logic [2:0] {BYTE = 3'd0, HALF = 3'd1, WORD = 3'd2, DWORD = 3'd3} hsize_e;
  typedef enum logic {OKAY = 1'b0, ERROR = 1'b1} hresp_e;
endpackage

// File: rtl/ahb_lite_master.sv
// ahb_lite_master: pipelined AHB-Lite initiator issuing SINGLE transfers from a valid/ready command port
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SIZE_WIDTH = 3,
  parameter int BURST_WIDTH = 3,
  parameter int TRANS_WIDTH = 2,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [ADDR_WIDTH-1:0]  cmd_addr,
  input  logic [SIZE_WIDTH-1:0]  cmd_size,
  input  logic [DATA_WIDTH-1:0]  cmd_wdata,
  output logic                   rsp_valid,
  output logic [DATA_WIDTH-1:0]  rsp_rdata,
  output logic                   rsp_err,
  output logic [ADDR_WIDTH-1:0]  HADDR,
  output logic                   HWRITE,
  output logic [SIZE_WIDTH-1:0]  HSIZE,
  output logic [BURST_WIDTH-1:0] HBURST,
  output logic [TRANS_WIDTH-1:0] HTRANS,
  output logic [DATA_WIDTH-1:0]  HWDATA,
  output logic [3:0]             HPROT,
  output logic                   HMASTLOCK,
  input  logic [DATA_WIDTH-1:0]  HRDATA,
  input  logic                   HREADY,
  input  logic                   HRESP
);
  logic                  ap_valid_q, ap_write_q;
  logic [ADDR_WIDTH-1:0] ap_addr_q;
  logic [SIZE_WIDTH-1:0] ap_size_q;
  logic [DATA_WIDTH-1:0] ap_wdata_q;
  logic                  dp_valid_q, dp_write_q;
  logic [DATA_WIDTH-1:0] dp_wdata_q;
  logic                  err_q;
  logic                  rsp_valid_q, rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  nonseq, accept;
  assign nonseq    = ap_valid_q & ~err_q;
  assign cmd_ready = HRESETn & ~err_q & (~ap_valid_q | HREADY);
  assign accept    = cmd_valid & cmd_ready;
  assign HADDR     = ap_addr_q;
  assign HWRITE    = ap_write_q;
  assign HSIZE     = ap_size_q;
  assign HTRANS    = TRANS_WIDTH'(nonseq ? NONSEQ : IDLE);
  assign HBURST    = BURST_WIDTH'(SINGLE);
  assign HWDATA    = dp_wdata_q;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  // Address/data pipeline slots, two-cycle error recovery and response capture
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      ap_valid_q  <= 1'b0;
      ap_write_q  <= 1'b0;
      ap_addr_q   <= '0;
      ap_size_q   <= '0;
      ap_wdata_q  <= '0;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_wdata_q  <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= HREADY & dp_valid_q;
      if (HREADY & dp_valid_q) begin
        rsp_rdata_q <= dp_write_q ? '0 : HRDATA;
        rsp_err_q   <= HRESP;
        err_q       <= 1'b0;
      end else if (HRESP & dp_valid_q) begin
        err_q <= 1'b1;
      end
      if (HREADY) begin
        dp_valid_q <= nonseq;
        if (nonseq) begin
          dp_write_q <= ap_write_q;
          dp_wdata_q <= ap_wdata_q;
        end
      end
      if (accept) begin
        ap_valid_q <= 1'b1;
        ap_write_q <= cmd_write;
        ap_addr_q  <= cmd_addr;
        ap_size_q  <= cmd_size;
        ap_wdata_q <= cmd_wdata;
      end else if (HREADY & ~err_q) begin
        ap_valid_q <= 1'b0;
      end
    end
  end
endmodule
